cam_update_engine: RTL

CAM_UPDATE_ENGINE -- requirements
Module: cam_update_engine

---
 rtl/cam_update_if.sv | 45 ++++
 rtl/cam_update_engine.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cam_update_if.sv
// Request handshake and slice-RAM bus of the CAM update engine.
// The clear_req signal exists only when CAM_UPDATE_CLEAR_EN is defined.
`timescale 1ns / 1ps

interface cam_update_if #(
    parameter int unsigned Depth      = 64,
    parameter int unsigned KeyWidth   = 24,
    parameter int unsigned SliceWidth = 6
);
    localparam int unsigned NumSlices = KeyWidth / SliceWidth;
    localparam int unsigned IdxWidth  = $clog2(Depth);

    logic                                req_valid;
    logic                                req_ready;
    logic                                req_op;
    logic [IdxWidth-1:0]                 req_idx;
    logic [KeyWidth-1:0]                 req_key;
    logic [SliceWidth-1:0]               ram_addr;
    logic                                ram_wen;
    logic [NumSlices-1:0][Depth-1:0]     ram_rdata;
    logic [NumSlices-1:0][Depth-1:0]     ram_wdata;
    logic                                busy;
    logic                                done;
`ifdef CAM_UPDATE_CLEAR_EN
    logic                                clear_req;
`endif

    // Requester / RAM side
    modport master (
`ifdef CAM_UPDATE_CLEAR_EN
        output clear_req,
`endif
        output req_valid, req_op, req_idx, req_key, ram_rdata,
        input  req_ready, ram_addr, ram_wen, ram_wdata, busy, done
    );

    // Engine side
    modport slave (
`ifdef CAM_UPDATE_CLEAR_EN
        input  clear_req,
`endif
        input  req_valid, req_op, req_idx, req_key, ram_rdata,
        output req_ready, ram_addr, ram_wen, ram_wdata, busy, done
    );
endinterface

// File: rtl/cam_update_engine.sv
// Sliced-RAM CAM update engine: sweeps every slice-RAM address once per request,
// read-modify-writing the target entry's bit in each slice (set where the key
// slice equals the address on insert, cleared everywhere else).
// Optional feature: define CAM_UPDATE_CLEAR_EN to add clear_req, which runs a
// sweep writing zero to every word of every slice.
`timescale 1ns / 1ps

module cam_update_engine #(
    parameter int unsigned Depth      = 64,
    parameter int unsigned KeyWidth   = 24,
    parameter int unsigned SliceWidth = 6
) (
    input  logic         clk,
    input  logic         rst,
    cam_update_if.slave  bus
);
    localparam int unsigned NumSlices = KeyWidth / SliceWidth;
    localparam int unsigned IdxWidth  = $clog2(Depth);

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e                state_q, state_d;
    logic [SliceWidth-1:0] cnt_q, cnt_d;
    logic                  op_q, op_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [KeyWidth-1:0]   key_q, key_d;
`ifdef CAM_UPDATE_CLEAR_EN
    logic                  clr_q, clr_d;
`endif

    // State, sweep counter and latched request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            key_q   <= '0;
`ifdef CAM_UPDATE_CLEAR_EN
            clr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
`ifdef CAM_UPDATE_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    // Next-state logic and all bus outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        idx_d         = idx_q;
        key_d         = key_q;
`ifdef CAM_UPDATE_CLEAR_EN
        clr_d         = clr_q;
`endif
        bus.req_ready = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wen   = 1'b0;
        bus.ram_wdata = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;

        unique case (state_q)
            StIdle: begin
`ifdef CAM_UPDATE_CLEAR_EN
                // Clear wins: the request is simply not ready this cycle
                bus.req_ready = ~bus.clear_req;
                if (bus.clear_req) begin
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StSweep;
                end else if (bus.req_valid) begin
                    clr_d   = 1'b0;
                    op_d    = bus.req_op;
                    idx_d   = bus.req_idx;
                    key_d   = bus.req_key;
                    cnt_d   = '0;
                    state_d = StSweep;
                end
`else
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    idx_d   = bus.req_idx;
                    key_d   = bus.req_key;
                    cnt_d   = '0;
                    state_d = StSweep;
                end
`endif
            end
            StSweep: begin
                bus.busy     = 1'b1;
                bus.ram_wen  = 1'b1;
                bus.ram_addr = cnt_q;
                for (int unsigned s = 0; s < NumSlices; s++) begin
                    bus.ram_wdata[s]        = bus.ram_rdata[s];
                    bus.ram_wdata[s][idx_q] = op_q &&
                        (key_q[s*SliceWidth +: SliceWidth] == cnt_q);
                end
`ifdef CAM_UPDATE_CLEAR_EN
                if (clr_q) begin
                    bus.ram_wdata = '0;
                end
`endif
                // Last address: leave without wrapping into a second pass
                if (&cnt_q) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule
